sensor_conditioner: RTL



---
 rtl/sensor_conditioner.sv | 101 ++++++++++
 1 files changed

// File: rtl/sensor_conditioner.sv
// Sync, debounce and plausibility-check stage for the six irrigation field inputs.
// Optional build macro: SENSOR_PLAUSIBILITY_EN enables the level/soil checks.
module sensor_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic h_raw,
  input  logic m_raw,
  input  logic l_raw,
  input  logic us_raw,
  input  logic ua_raw,
  input  logic t_raw,
  output logic h,
  output logic m,
  output logic l,
  output logic us,
  output logic ua,
  output logic t,
  output logic level_fault,
  output logic soil_fault,
  output logic changed
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  // Bit order everywhere: {h, m, l, us, ua, t}
  logic [5:0]    raw;
  logic [5:0]    s1;
  logic [5:0]    s2;
  logic [5:0]    stable;
  logic [CW-1:0] cnt [6];
  logic [5:0]    outs;
  logic [5:0]    nxt;
  logic          lf_n;
  logic          sf_n;

  assign raw = {h_raw, m_raw, l_raw, us_raw, ua_raw, t_raw};

  always_ff @(posedge clk) begin
    if (rst) begin
      s1     <= '0;
      s2     <= '0;
      stable <= '0;
      for (int i = 0; i < 6; i++) cnt[i] <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      for (int i = 0; i < 6; i++) begin
        if (s2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == LAST) begin
          stable[i] <= s2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  always_comb begin
    nxt  = outs;
    lf_n = 1'b0;
    sf_n = 1'b0;
`ifdef SENSOR_PLAUSIBILITY_EN
    // Probes fill bottom-up, so only contiguous-from-low patterns are real
    case (stable[5:3])
      3'b000, 3'b001,
      3'b011, 3'b111: nxt[5:3] = stable[5:3];
      default:        lf_n     = 1'b1;
    endcase
    if (stable[2] && stable[1]) begin
      sf_n = 1'b1;
    end else begin
      nxt[2:1] = stable[2:1];
    end
    nxt[0] = stable[0];
`else
    nxt = stable;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outs        <= '0;
      level_fault <= 1'b0;
      soil_fault  <= 1'b0;
      changed     <= 1'b0;
    end else begin
      outs        <= nxt;
      level_fault <= lf_n;
      soil_fault  <= sf_n;
      changed     <= (nxt != outs);
    end
  end

  assign {h, m, l, us, ua, t} = outs;

endmodule
